mem_access_unit: RTL and testbench

//  MEM stage of the pipelined MIPS core. Takes EX/MEM fields (ALU result, store data, control) and runs LW/SW over a
//  req/ack data bus with variable latency. Stalls the upstream pipeline while a bus access is outstanding.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mau_timeout_ctr.sv | 28 ++
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core constants and the MEM-stage access-unit state encoding.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mau_state_t;

endpackage

// File: rtl/mau_timeout_ctr.sv
// Watchdog for an outstanding data-bus request: expired pulses on the REQ cycle
// in which the LIMIT-th consecutive unacknowledged cycle is reached.
module mau_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 4'd0;
    end else if (clear) begin
      count_reg <= 4'd0;
    end else if (enable) begin
      count_reg <= count_reg + 4'd1;
    end
  end

  // The increment taken this cycle would reach LIMIT, so abort now.
  assign expired = enable && (count_reg == 4'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs LW/SW over a req/ack bus, stalls upstream while busy, owns MEM/WB.
// Optional request watchdog enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_wb_addr,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_load_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_AW-1:0] wb_addr,
  output logic              mem_err
);

  mau_state_t        state_reg, state_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              mem_op, aligned;
  logic              start_req, start_err, ack_take, abort, timeout_hit;

  assign mem_op  = ex_valid && (ex_mem_read || ex_mem_write);
  assign aligned = (ex_alu_result[1:0] == 2'b00);

`ifdef MAU_TIMEOUT_EN
  mau_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_req),
    .enable ((state_reg == ST_REQ) && !bus_ack),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    start_req  = 1'b0;
    start_err  = 1'b0;
    ack_take   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_op) begin
          stall = 1'b1;
          if (aligned) begin
            start_req  = 1'b1;
            state_next = ST_REQ;
          end else begin
            start_err  = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          ack_take   = 1'b1;
          state_next = ST_DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus side: request fields are latched once and held until the access ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      if (start_req) begin
        bus_req   <= 1'b1;
        bus_we    <= ex_mem_write;
        bus_addr  <= {ex_alu_result[DATA_W-1:2], 2'b00};
        bus_wdata <= ex_store_data;
      end else if (ack_take || abort) begin
        bus_req <= 1'b0;
      end
      if (ack_take) rdata_reg <= bus_rdata;
      if (start_err || abort) begin
        err_reg <= 1'b1;
        mem_err <= 1'b1;
      end else if (state_reg == ST_DONE) begin
        err_reg <= 1'b0;
      end
    end
  end

  // MEM/WB register: bubble while stalled, completed access from DONE, else pass-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_load_data  <= '0;
      wb_alu_result <= '0;
      wb_addr       <= '0;
    end else if (stall) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_load_data  <= '0;
      wb_alu_result <= '0;
      wb_addr       <= '0;
    end else if (state_reg == ST_DONE) begin
      wb_valid      <= 1'b1;
      wb_reg_write  <= ex_reg_write && !err_reg;
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_load_data  <= err_reg ? '0 : rdata_reg;
      wb_alu_result <= ex_alu_result;
      wb_addr       <= ex_wb_addr;
    end else begin
      wb_valid      <= ex_valid;
      wb_reg_write  <= ex_valid && ex_reg_write;
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_load_data  <= '0;
      wb_alu_result <= ex_alu_result;
      wb_addr       <= ex_wb_addr;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a variable-latency bus responder and a
// MEM/WB scoreboard. Timeout scenario runs only when MAU_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0, ex_mem_to_reg = 1'b0;
  logic [31:0] ex_alu_result = '0, ex_store_data = '0;
  logic [4:0]  ex_wb_addr = '0;
  logic        stall, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, mem_err;
  logic [31:0] wb_load_data, wb_alu_result;
  logic [4:0]  wb_addr;

  typedef struct {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] load_data;
    logic [31:0] alu;
    logic [4:0]  addr;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  int compared = 0;
  int mismatched = 0;
  int ack_at = 0;
  logic [31:0] rdata_cfg = '0;
  logic exp_mem_err = 1'b0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_wb_addr(ex_wb_addr),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_load_data(wb_load_data), .wb_alu_result(wb_alu_result), .wb_addr(wb_addr),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Responder: acks during the ack_at-th consecutive request cycle (0 = never).
  initial begin
    int req_seen;
    req_seen  = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0BAD_0BAD;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        req_seen++;
        bus_ack   = (ack_at != 0) && (req_seen == ack_at);
        bus_rdata = bus_ack ? rdata_cfg : 32'h0BAD_0BAD;
      end else begin
        req_seen  = 0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0BAD_0BAD;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction (caller is just after a negedge) and follow it to MEM/WB.
  task automatic do_op(input string name, input logic rd, input logic wr, input logic rw,
                       input logic m2r, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] wa, input int ack_n, input logic [31:0] rdata,
                       input int exp_stall, input int exp_req, input logic err);
    wb_exp_t e, got;
    int stall_cnt, req_cnt;
    bit done;
    ack_at = ack_n;
    rdata_cfg = rdata;
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
    ex_mem_to_reg = m2r; ex_alu_result = alu; ex_store_data = sd; ex_wb_addr = wa;
    e.valid = 1'b1;
    e.reg_write = rw && !err;
    e.mem_to_reg = m2r;
    e.load_data = (err || !(rd || wr)) ? 32'h0 : rdata;
    e.alu = alu;
    e.addr = wa;
    wb_q.push_back(e);
    if (err) exp_mem_err = 1'b1;
    stall_cnt = 0; req_cnt = 0; done = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (bus_req) begin
        req_cnt++;
        if (req_cnt == 1 || req_cnt == exp_req) begin
          check({name, " bus_addr"}, bus_addr, {alu[31:2], 2'b00});
          check({name, " bus_we"}, {31'b0, bus_we}, {31'b0, wr});
          if (wr) check({name, " bus_wdata"}, bus_wdata, sd);
        end
      end
      if (stall) stall_cnt++;
      else begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    check({name, " completes"}, {31'b0, done}, 32'd1);
    check({name, " stall cycles"}, stall_cnt, exp_stall);
    check({name, " req cycles"}, req_cnt, exp_req);
    @(posedge clk);
    #1;
    check({name, " wb_valid"}, {31'b0, wb_valid}, 32'd1);
    if (wb_valid && wb_q.size() > 0) begin
      got = wb_q.pop_front();
      check({name, " wb_reg_write"}, {31'b0, wb_reg_write}, {31'b0, got.reg_write});
      check({name, " wb_mem_to_reg"}, {31'b0, wb_mem_to_reg}, {31'b0, got.mem_to_reg});
      check({name, " wb_load_data"}, wb_load_data, got.load_data);
      check({name, " wb_alu_result"}, wb_alu_result, got.alu);
      check({name, " wb_addr"}, {27'b0, wb_addr}, {27'b0, got.addr});
    end
    check({name, " mem_err"}, {31'b0, mem_err}, {31'b0, exp_mem_err});
    $display("op %s: alu=%h stall=%0d req=%0d wb_load=%h", name, alu, stall_cnt, req_cnt, wb_load_data);
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    ex_mem_to_reg = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check({name, " bubble after"}, {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset bus_req", {31'b0, bus_req}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset mem_err", {31'b0, mem_err}, 32'd0);
    check("reset wb_alu_result", wb_alu_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("alu",   0, 0, 1, 0, 32'h0000_0010, 32'h0,      5'd5,  0, 32'h0,         0, 0, 0);
    do_op("lw",    1, 0, 1, 1, 32'h0000_0024, 32'h0,      5'd9,  1, 32'hDEAD_BEEF, 2, 1, 0);
    do_op("sw",    0, 1, 0, 0, 32'h0000_0008, 32'h1234,   5'd0,  4, 32'hAAAA_5555, 5, 4, 0);
    do_op("lw2",   1, 0, 1, 1, 32'h0000_0100, 32'h0,      5'd31, 2, 32'h0123_4567, 3, 2, 0);
    do_op("alu2",  0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0,      5'd17, 0, 32'h0,         0, 0, 0);
    do_op("lw_mis",1, 0, 1, 1, 32'h0000_0026, 32'h0,      5'd3,  1, 32'h5555_AAAA, 1, 0, 1);
    do_op("alu3",  0, 0, 1, 0, 32'h0000_0042, 32'h0,      5'd7,  0, 32'h0,         0, 0, 0);
`ifdef MAU_TIMEOUT_EN
    do_op("lw_to", 1, 0, 1, 1, 32'h0000_0040, 32'h0,      5'd4,  0, 32'h0,        16, 15, 1);
`endif

    // Reset in the middle of an access that never gets acked.
    ack_at = 0;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_result = 32'h0000_0080; ex_wb_addr = 5'd2;
    repeat (3) @(negedge clk);
    #1;
    check("pre-reset bus_req", {31'b0, bus_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset bus_req", {31'b0, bus_req}, 32'd0);
    check("async reset mem_err", {31'b0, mem_err}, 32'd0);
    exp_mem_err = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset stall", {31'b0, stall}, 32'd0);
    check("post-reset bus_req", {31'b0, bus_req}, 32'd0);
    @(negedge clk);
    do_op("alu_rst", 0, 0, 1, 0, 32'h0000_0099, 32'h0, 5'd12, 0, 32'h0, 0, 0, 0);

    check("scoreboard drained", wb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
